dict_hash_feeder: RTL
=====================

Name: dict_hash_feeder

Overview:
Initiator side of the password/dictionary compare path. It walks a synchronous dictionary-hash memory one word at a time and presents each hashed dictionary word with the latched hashed password to the downstream comparator. It waits the comparator's fixed latency, samples the match result, and stops on the first match or on dictionary exhaustion. Sits between the dictionary BRAM and the compare/selectWord stage; reports the index and hash of the matching word to the control process.

Parameters:
HASH_W, 161, hash bus width (matches existing [20*8:0] hash buses)
ADDR_W, 10, dictionary memory address width
CMP_LAT, 2, cycles from dic_out/pass_out stable to match_in valid (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin search; sampled only in IDLE, FOUND, NOTFOUND
abort  in  1  abandon search, return to IDLE
pass_in  in  HASH_W  hashed password, latched on accepted start
dict_len  in  ADDR_W+1  number of dictionary words (0..2^ADDR_W), latched on start
mem_addr  out  ADDR_W  dictionary memory read address
mem_rdata  in  HASH_W  memory read data, valid 1 cycle after mem_addr
pass_out  out  HASH_W  latched password hash to comparator
dic_out  out  HASH_W  current dictionary hash to comparator
match_in  in  1  comparator result (1 = equal)
busy  out  1  search in progress
found  out  1  sticky: match located
not_found  out  1  sticky: dictionary exhausted, no match
match_idx  out  ADDR_W  index of matching word
match_word  out  HASH_W  hash of matching word

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (mem_addr, pass_out, dic_out, busy, found, not_found, match_idx, match_word).
- States: IDLE, READ, LOAD, WAIT, FOUND, NOTFOUND.
- IDLE/FOUND/NOTFOUND + start=1: latch pass_in->pass_out, dict_len, idx=0, mem_addr=0; clear found/not_found, match_idx, match_word; busy=1. If dict_len==0 go NOTFOUND (not_found=1, busy=0) on the same edge, else READ.
- READ (1 cycle): mem_addr=idx held; memory read in flight.
- LOAD (1 cycle): capture mem_rdata->dic_out; load wait counter = CMP_LAT-1; go WAIT.
- WAIT (CMP_LAT cycles): counter decrements each cycle. When counter==0, sample match_in:
  - match_in=1: match_idx=idx, match_word=dic_out, found=1, busy=0 -> FOUND.
  - match_in=0 and idx==dict_len-1: not_found=1, busy=0 -> NOTFOUND.
  - else: idx+1, mem_addr=idx+1 -> READ.
- match_in is ignored outside the sampling cycle.
- Throughput: CMP_LAT+2 cycles per word. found rises exactly (k+1)*(CMP_LAT+2) edges after the start-accepting edge for a match at index k.
- FOUND/NOTFOUND are sticky. match_idx, match_word, dic_out and pass_out hold until the next accepted start or abort.
- start while busy: ignored.
- abort (any state, priority over start and match): next edge -> IDLE. busy, found and not_found become 0. Data outputs hold.
- Full dictionary (dict_len=2^ADDR_W): idx compare uses ADDR_W+1 bits; no wrap. Last index is 2^ADDR_W-1.
- Address never exceeds dict_len-1.

Decomposition:
- Shared package: HASH_W default, state enum (IDLE, READ, LOAD, WAIT, FOUND, NOTFOUND), CMP_LAT default shared with the compare stage.
- No sub-module. Single FSM with index counter and latency counter; the comparator stays external.

Test Plan:
- dict_len=3, mem={A,B,C}, pass=B, CMP_LAT=2, comparator model -> found=1 exactly 8 edges after start; match_idx=1, match_word=B; mem_addr sequence 0,1; busy low with found.
- dict_len=3, pass matches none -> not_found=1 exactly 12 edges after start; found=0; mem_addr never reaches 3.
- dict_len=0, start -> not_found=1 after 1 edge; mem_addr stays 0; no match_in sampling.
- Abort during WAIT of word 1 -> IDLE next edge, busy=0, found=0; then start with pass=A -> found after 4 edges, match_idx=0.
- match_in pulsed 1 in non-sampling WAIT cycle of word 0 (real result 0), pass=C -> ignored; found at idx 2 after 12 edges. start pulsed while busy -> no restart.
- rst_n asserted mid-search (LOAD) -> all outputs 0 immediately (async). After release, start with dict_len=2^ADDR_W, match in last word -> match_idx=2^ADDR_W-1, no address wrap.

Source files
------------

// File: rtl/dict_hash_feeder_pkg.sv
// Shared constants and FSM state type for the dictionary hash feeder.
// CMP_LAT default is shared with the downstream compare stage.
package dict_hash_feeder_pkg;

    localparam int DHF_HASH_W  = 161;
    localparam int DHF_ADDR_W  = 10;
    localparam int DHF_CMP_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_WAIT,
        S_FOUND,
        S_NOTFOUND
    } dhf_state_t;

endpackage

// File: rtl/dict_hash_feeder.sv
// Walks the dictionary hash memory and feeds each word plus the latched
// password hash to an external comparator; stops on match or exhaustion.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        begin search / abandon search
//   pass_in, dict_len   password hash and word count, latched on start
//   mem_addr, mem_rdata dictionary memory (1-cycle read latency)
//   pass_out, dic_out   operands to the comparator
//   match_in            comparator result, valid CMP_LAT cycles later
//   busy, found, not_found, match_idx, match_word   status / result
module dict_hash_feeder
    import dict_hash_feeder_pkg::*;
#(
    parameter int HASH_W  = DHF_HASH_W,
    parameter int ADDR_W  = DHF_ADDR_W,
    parameter int CMP_LAT = DHF_CMP_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HASH_W-1:0] pass_in,
    input  logic [ADDR_W:0]   dict_len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [HASH_W-1:0] mem_rdata,
    output logic [HASH_W-1:0] pass_out,
    output logic [HASH_W-1:0] dic_out,
    input  logic              match_in,
    output logic              busy,
    output logic              found,
    output logic              not_found,
    output logic [ADDR_W-1:0] match_idx,
    output logic [HASH_W-1:0] match_word
);

    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [CW-1:0]   CNT_LD = CW'(CMP_LAT - 1);

    dhf_state_t r_state;
    dhf_state_t w_state_nxt;

    // Index and length are one bit wider than the address so a
    // full 2^ADDR_W dictionary is representable without wrap.
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   r_len;
    logic [CW-1:0]     r_cnt;
    logic [HASH_W-1:0] r_pass;
    logic [HASH_W-1:0] r_dic;
    logic [HASH_W-1:0] r_mword;
    logic [ADDR_W-1:0] r_midx;

    logic w_idle_like;
    logic w_accept;
    logic w_sample;
    logic w_last;

    assign w_idle_like = (r_state == S_IDLE)  ||
                         (r_state == S_FOUND) ||
                         (r_state == S_NOTFOUND);
    assign w_accept = start && w_idle_like && !abort;
    assign w_sample = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_last   = (r_idx == (r_len - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_FOUND, S_NOTFOUND: begin
                    if (start) begin
                        w_state_nxt = (dict_len == '0) ? S_NOTFOUND
                                                       : S_READ;
                    end
                end
                S_READ: w_state_nxt = S_LOAD;
                S_LOAD: w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (w_sample) begin
                        if (match_in) begin
                            w_state_nxt = S_FOUND;
                        end else if (w_last) begin
                            w_state_nxt = S_NOTFOUND;
                        end else begin
                            w_state_nxt = S_READ;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath; abort freezes all data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_pass  <= '0;
            r_dic   <= '0;
            r_mword <= '0;
            r_midx  <= '0;
        end else if (!abort) begin
            if (w_accept) begin
                r_pass  <= pass_in;
                r_len   <= dict_len;
                r_idx   <= '0;
                r_midx  <= '0;
                r_mword <= '0;
            end
            if (r_state == S_LOAD) begin
                r_dic <= mem_rdata;
                r_cnt <= CNT_LD;
            end
            if (r_state == S_WAIT) begin
                if (!w_sample) begin
                    r_cnt <= r_cnt - CW'(1);
                end else if (match_in) begin
                    r_midx  <= r_idx[ADDR_W-1:0];
                    r_mword <= r_dic;
                end else if (!w_last) begin
                    r_idx <= r_idx + ONE;
                end
            end
        end
    end

    assign mem_addr   = r_idx[ADDR_W-1:0];
    assign pass_out   = r_pass;
    assign dic_out    = r_dic;
    assign match_idx  = r_midx;
    assign match_word = r_mword;
    assign busy       = (r_state == S_READ) ||
                        (r_state == S_LOAD) ||
                        (r_state == S_WAIT);
    assign found      = (r_state == S_FOUND);
    assign not_found  = (r_state == S_NOTFOUND);

endmodule
